// File: rtl/sim_mem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sim_mem_bridge_pkg : shared constants and types for the simulation memory bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sim_mem_bridge_pkg;

   localparam logic [63:0] PC_START_DEF = 64'h0000_0000_8000_0000;
   localparam int          IDX_W_DEF    = 16;

   localparam logic [2:0] SIZE_B = 3'd0;
   localparam logic [2:0] SIZE_H = 3'd1;
   localparam logic [2:0] SIZE_W = 3'd2;
   localparam logic [2:0] SIZE_D = 3'd3;

   typedef enum logic [1:0] {
      MB_IDLE   = 2'd0,
      MB_ACCESS = 2'd1,
      MB_RESP   = 2'd2
   } mb_state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_LS = 1'b1
   } req_id_e;

   typedef struct packed {
      req_id_e     id;
      logic [63:0] addr;
      logic [2:0]  size;
      logic        wen;
      logic [63:0] wdata;
   } req_t;

   // Illegal sizes map to zero bytes, which yields an empty byte mask.
   function automatic logic [3:0] size_bytes(input logic [2:0] size);
      case (size)
         SIZE_B:  return 4'd1;
         SIZE_H:  return 4'd2;
         SIZE_W:  return 4'd4;
         SIZE_D:  return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/sim_mem_bridge_if.sv
// ---------------------------------------------------------------------------
// sim_mem_bridge_if : fetch, load/store and RAMHelper signals of the memory bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sim_mem_bridge_if #(
   parameter int IDX_W = 16
);
   logic             if_req_valid;
   logic             if_req_ready;
   logic [63:0]      if_addr;
   logic             if_rsp_valid;
   logic [31:0]      if_rsp_data;

   logic             ls_req_valid;
   logic             ls_req_ready;
   logic             ls_wen;
   logic [63:0]      ls_addr;
   logic [2:0]       ls_size;
   logic [63:0]      ls_wdata;
   logic             ls_rsp_valid;
   logic [63:0]      ls_rsp_data;

   logic             rsp_err;

   logic             ram_en;
   logic [IDX_W-1:0] ram_idx;
   logic [63:0]      ram_wdata;
   logic [63:0]      ram_wmask;
   logic             ram_wen;
   logic [63:0]      ram_rdata;

   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  ls_req_valid, ls_wen, ls_addr, ls_size, ls_wdata,
      output ls_req_ready, ls_rsp_valid, ls_rsp_data,
      output rsp_err,
      output ram_en, ram_idx, ram_wdata, ram_wmask, ram_wen,
      input  ram_rdata
   );

   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output ls_req_valid, ls_wen, ls_addr, ls_size, ls_wdata,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
      input  rsp_err,
      input  ram_en, ram_idx, ram_wdata, ram_wmask, ram_wen,
      output ram_rdata
   );

endinterface

`default_nettype wire

// File: rtl/sim_mem_bridge_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align : byte-lane masks, store-data shift and load-data extraction
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
   import sim_mem_bridge_pkg::*;
(
   input  logic [2:0]  offset_i,
   input  logic [2:0]  size_i,
   input  logic [63:0] wdata_i,
   input  logic [63:0] rdata_i,
   output logic [7:0]  bmask_o,
   output logic [63:0] wmask_o,
   output logic [63:0] wdata_o,
   output logic [63:0] rdata_o,
   output logic        misalign_o
);

   logic [3:0]  w_nbytes;
   logic [7:0]  w_span;
   logic [63:0] w_keep;
   logic [63:0] w_rshift;

   assign w_nbytes   = size_bytes(size_i);
   assign w_span     = 8'hFF >> (4'd8 - w_nbytes);
   assign bmask_o    = w_span << offset_i;
   assign misalign_o = ({1'b0, offset_i} + w_nbytes) > 4'd8;

   assign wdata_o  = wdata_i << {offset_i, 3'b000};
   assign w_rshift = rdata_i >> {offset_i, 3'b000};
   assign rdata_o  = w_rshift & w_keep;

   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign wmask_o[8*i +: 8] = {8{bmask_o[i]}};
      assign w_keep[8*i +: 8]  = {8{w_span[i]}};
   end

endmodule

`default_nettype wire

// File: rtl/sim_mem_bridge.sv
// ---------------------------------------------------------------------------
// sim_mem_bridge : arbitrates fetch and load/store requests onto the RAMHelper model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sim_mem_bridge
   import sim_mem_bridge_pkg::*;
#(
   parameter logic [63:0] PC_START = PC_START_DEF,
   parameter int          IDX_W    = IDX_W_DEF
)
(
   input  logic             clock,
   input  logic             reset,
   sim_mem_bridge_if.slave  bus
);

   mb_state_e   state_q, state_d;
   req_t        req_q, req_d;
   logic [31:0] if_data_q, if_data_d;
   logic [63:0] ls_data_q, ls_data_d;
   logic        err_q, err_d;

   logic [63:0] w_word;
   logic        w_below;
   logic        w_oor;
   logic        w_badsize;
   logic        w_misalign;
   logic        w_err;
   logic [7:0]  w_bmask;
   logic [63:0] w_wmask;
   logic [63:0] w_wdata;
   logic [63:0] w_rdata;
   logic [63:0] w_rsp;

   mem_lane_align u_align (
      .offset_i   (req_q.addr[2:0]),
      .size_i     (req_q.size),
      .wdata_i    (req_q.wdata),
      .rdata_i    (bus.ram_rdata),
      .bmask_o    (w_bmask),
      .wmask_o    (w_wmask),
      .wdata_o    (w_wdata),
      .rdata_o    (w_rdata),
      .misalign_o (w_misalign)
   );

   assign w_word    = (req_q.addr - PC_START) >> 3;
   assign w_below   = req_q.addr < PC_START;
   assign w_oor     = |w_word[63:IDX_W];
   // An empty byte mask only arises for the illegal sizes 4..7.
   assign w_badsize = (w_bmask == 8'h00);
   assign w_err     = w_below | w_oor | w_badsize | w_misalign;
   assign w_rsp     = w_err ? 64'd0 : w_rdata;

   assign bus.if_rsp_data = if_data_q;
   assign bus.ls_rsp_data = ls_data_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= MB_IDLE;
         req_q     <= '0;
         if_data_q <= '0;
         ls_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         if_data_q <= if_data_d;
         ls_data_q <= ls_data_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      req_d            = req_q;
      if_data_d        = if_data_q;
      ls_data_d        = ls_data_q;
      err_d            = err_q;
      bus.if_req_ready = 1'b0;
      bus.ls_req_ready = 1'b0;
      bus.if_rsp_valid = 1'b0;
      bus.ls_rsp_valid = 1'b0;
      bus.rsp_err      = 1'b0;
      bus.ram_en       = 1'b0;
      bus.ram_wen      = 1'b0;
      bus.ram_idx      = '0;
      bus.ram_wdata    = '0;
      bus.ram_wmask    = '0;

      case (state_q)
         MB_IDLE: begin
            // The LSU has priority over instruction fetch.
            bus.ls_req_ready = bus.ls_req_valid;
            bus.if_req_ready = bus.if_req_valid & ~bus.ls_req_valid;
            if (bus.ls_req_valid) begin
               req_d   = '{id: REQ_LS, addr: bus.ls_addr, size: bus.ls_size,
                           wen: bus.ls_wen, wdata: bus.ls_wdata};
               state_d = MB_ACCESS;
            end else if (bus.if_req_valid) begin
               req_d   = '{id: REQ_IF, addr: bus.if_addr, size: SIZE_W,
                           wen: 1'b0, wdata: 64'd0};
               state_d = MB_ACCESS;
            end
         end

         MB_ACCESS: begin
            err_d = w_err;
            if (!w_err) begin
               bus.ram_en    = 1'b1;
               bus.ram_wen   = req_q.wen;
               bus.ram_idx   = w_word[IDX_W-1:0];
               bus.ram_wdata = w_wdata;
               bus.ram_wmask = w_wmask;
            end
            if (req_q.id == REQ_IF) begin
               if_data_d = w_rsp[31:0];
            end else begin
               ls_data_d = w_rsp;
            end
            state_d = MB_RESP;
         end

         MB_RESP: begin
            bus.if_rsp_valid = (req_q.id == REQ_IF);
            bus.ls_rsp_valid = (req_q.id == REQ_LS);
            bus.rsp_err      = err_q;
            state_d          = MB_IDLE;
         end

         default: begin
            state_d = MB_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_sim_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_sim_mem_bridge : directed and randomized checks of sim_mem_bridge against a byte-level memory model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sim_mem_bridge;
   import sim_mem_bridge_pkg::*;

   localparam logic [63:0] PCS = 64'h0000_0000_8000_0000;
   localparam int          IW  = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;

   sim_mem_bridge_if #(.IDX_W(IW)) bus();

   sim_mem_bridge #(.PC_START(PCS), .IDX_W(IW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // RAMHelper stand-in: combinational read, masked write at the clock edge.
   logic [63:0] ram [0:63];
   assign bus.ram_rdata = ram[bus.ram_idx[5:0]];
   always @(posedge clock) begin
      if (bus.ram_en && bus.ram_wen)
         ram[bus.ram_idx[5:0]] <= (ram[bus.ram_idx[5:0]] & ~bus.ram_wmask) |
                                  (bus.ram_wdata & bus.ram_wmask);
   end

   int total = 0;
   int bad   = 0;
   logic [7:0] mref [longint];

   function automatic logic [7:0] ref_byte(input logic [63:0] a);
      longint k;
      k = longint'(a);
      return mref.exists(k) ? mref[k] : 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete request: accept, RAM access, response; checked against the byte model.
   task automatic xact(input bit use_if, input bit wen_in, input logic [63:0] addr,
                       input logic [2:0] size_in, input logic [63:0] wdata_in,
                       output logic [63:0] rdata, output logic rerr);
      int          n, off;
      bit          err, got, wen;
      logic [2:0]  size;
      logic [63:0] wdata, rel, exp_mask, exp_wd, exp_rd, obs;
      wen   = use_if ? 1'b0 : wen_in;
      size  = use_if ? 3'd2 : size_in;
      wdata = use_if ? 64'd0 : wdata_in;
      n     = (size <= 3'd3) ? (1 << size) : 0;
      off   = int'(addr[2:0]);
      rel   = addr - PCS;
      err   = (addr < PCS) || ((rel >> 3) >= (64'd1 << IW)) || (size > 3'd3) || (off + n > 8);
      exp_mask = '0; exp_wd = '0; exp_rd = '0;
      for (int b = 0; b < 8; b++) begin
         if (b >= off && b < off + n) begin
            exp_mask[8*b +: 8] = 8'hFF;
            exp_wd[8*b +: 8]   = wdata[8*(b-off) +: 8];
         end
      end
      if (!err)
         for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = ref_byte(addr + 64'(k));

      @(negedge clock);
      if (use_if) begin
         bus.if_req_valid = 1'b1;
         bus.if_addr      = addr;
      end else begin
         bus.ls_req_valid = 1'b1;
         bus.ls_wen       = wen;
         bus.ls_addr      = addr;
         bus.ls_size      = size;
         bus.ls_wdata     = wdata;
      end
      #1;
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
         if (use_if ? bus.if_req_ready : bus.ls_req_ready) got = 1'b1;
         else @(negedge clock);
      end
      chk("accept", 64'(got), 64'd1);
      @(posedge clock);
      #1;
      bus.if_req_valid = 1'b0;
      bus.ls_req_valid = 1'b0;

      @(negedge clock);
      chk("access_ram_en", 64'(bus.ram_en), 64'(!err));
      chk("access_no_err", 64'(bus.rsp_err), 64'd0);
      if (!err) begin
         chk("ram_idx", 64'(bus.ram_idx), rel >> 3);
         chk("ram_wen", 64'(bus.ram_wen), 64'(wen));
         chk("ram_wmask", bus.ram_wmask, exp_mask);
         if (wen) chk("ram_wdata", bus.ram_wdata & exp_mask, exp_wd);
      end

      @(negedge clock);
      chk("if_rsp_valid", 64'(bus.if_rsp_valid), 64'(use_if));
      chk("ls_rsp_valid", 64'(bus.ls_rsp_valid), 64'(!use_if));
      chk("rsp_err", 64'(bus.rsp_err), 64'(err));
      obs = use_if ? {32'd0, bus.if_rsp_data} : bus.ls_rsp_data;
      chk("rsp_data", obs, exp_rd);
      rdata = obs;
      rerr  = bus.rsp_err;

      if (wen && !err)
         for (int k = 0; k < n; k++) mref[longint'(addr + 64'(k))] = wdata[8*k +: 8];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d, a, wd;
      logic        e;
      bit          kind_if, kind_st;
      logic [2:0]  sz;

      bus.if_req_valid = 1'b0; bus.if_addr  = '0;
      bus.ls_req_valid = 1'b0; bus.ls_wen   = 1'b0; bus.ls_addr = '0;
      bus.ls_size      = '0;   bus.ls_wdata = '0;

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_rsp_valid", 64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_ram_en", 64'({bus.ram_en, bus.ram_wen}), 64'd0);
      chk("rst_ready", 64'({bus.if_req_ready, bus.ls_req_ready}), 64'd0);
      chk("rst_ls_data", bus.ls_rsp_data, 64'd0);

      // Fill the low words through the bridge itself.
      xact(0, 1, PCS, 3'd3, 64'h1111_2222_3333_4444, d, e);
      for (int w = 1; w < 16; w++)
         xact(0, 1, PCS + 64'(8*w), 3'd3, {$urandom, $urandom}, d, e);

      xact(1, 0, PCS + 64'h4, 3'd2, 64'd0, d, e);
      chk("t1_fetch_data", d, 64'h1111_2222);

      xact(0, 1, PCS + 64'h13, 3'd0, 64'hAB, d, e);
      xact(0, 0, PCS + 64'h13, 3'd0, 64'd0, d, e);
      chk("t2_load_back", d, 64'hAB);

      // Simultaneous requests: the LSU wins, fetch follows its response.
      @(negedge clock);
      bus.if_req_valid = 1'b1; bus.if_addr = PCS + 64'h8;
      bus.ls_req_valid = 1'b1; bus.ls_wen = 1'b0; bus.ls_addr = PCS + 64'h10;
      bus.ls_size = 3'd3;
      #1;
      chk("arb_ls_ready", 64'(bus.ls_req_ready), 64'd1);
      chk("arb_if_ready", 64'(bus.if_req_ready), 64'd0);
      @(posedge clock);
      #1 bus.ls_req_valid = 1'b0;
      @(negedge clock);
      chk("arb_if_wait_access", 64'(bus.if_req_ready), 64'd0);
      @(negedge clock);
      chk("arb_ls_rsp", 64'(bus.ls_rsp_valid), 64'd1);
      chk("arb_if_wait_resp", 64'(bus.if_req_ready), 64'd0);
      for (int k = 0; k < 8; k++) a[8*k +: 8] = ref_byte(PCS + 64'h10 + 64'(k));
      chk("arb_ls_data", bus.ls_rsp_data, a);
      @(negedge clock);
      chk("arb_if_accept", 64'(bus.if_req_ready), 64'd1);
      @(posedge clock);
      #1 bus.if_req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("arb_if_rsp", 64'(bus.if_rsp_valid), 64'd1);
      for (int k = 0; k < 4; k++) a[8*k +: 8] = ref_byte(PCS + 64'h8 + 64'(k));
      chk("arb_if_data", {32'd0, bus.if_rsp_data}, {32'd0, a[31:0]});

      xact(0, 0, PCS + 64'h6, 3'd2, 64'd0, d, e);
      chk("t4_misalign_err", 64'(e), 64'd1);
      xact(0, 0, 64'h7FFF_FFF8, 3'd3, 64'd0, d, e);
      xact(0, 0, PCS + (64'd8 << IW), 3'd3, 64'd0, d, e);
      chk("t5_oor_err", 64'(e), 64'd1);
      xact(0, 1, PCS + (64'd8 << IW) - 64'd8, 3'd3, 64'hDEAD_BEEF_0BAD_F00D, d, e);
      xact(0, 0, PCS + (64'd8 << IW) - 64'd4, 3'd2, 64'd0, d, e);
      xact(0, 0, PCS + 64'h20, 3'd5, 64'd0, d, e);
      xact(0, 1, PCS + 64'h1E, 3'd1, 64'h5A5A, d, e);

      // Reset during ACCESS drops the in-flight load.
      @(negedge clock);
      bus.ls_req_valid = 1'b1; bus.ls_wen = 1'b0; bus.ls_addr = PCS + 64'h8;
      bus.ls_size = 3'd3;
      @(posedge clock);
      #1 bus.ls_req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("t6_rsp_valid", 64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
      chk("t6_ram_en", 64'({bus.ram_en, bus.ram_wen, bus.rsp_err}), 64'd0);
      chk("t6_ram_bus", bus.ram_wmask | bus.ram_wdata | 64'(bus.ram_idx), 64'd0);
      chk("t6_rsp_data", bus.ls_rsp_data | {32'd0, bus.if_rsp_data}, 64'd0);
      @(negedge clock);
      chk("t6_still_quiet", 64'({bus.ls_rsp_valid, bus.ram_en}), 64'd0);
      xact(0, 0, PCS + 64'h8, 3'd3, 64'd0, d, e);

      for (int i = 0; i < 40; i++) begin
         kind_if = ($urandom_range(0, 2) == 0);
         kind_st = ($urandom_range(0, 1) == 1);
         a       = PCS + 64'($urandom_range(0, 127));
         sz      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         wd      = {$urandom, $urandom};
         xact(kind_if, kind_st, a, sz, wd, d, e);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
